// File: rtl/alu_seq_pkg.sv
// Shared types, limits and helpers for the ALU test sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 1024;
  localparam int WIDTH_WARN = 256;
  localparam int SETS_MIN   = 1;
  localparam int SETS_MAX   = 1000;
  localparam int SETS_WARN  = 500;

  // Counter width able to hold 0..sets. All-ones is then never a valid
  // vector index (max index is sets-1 <= 2**cw-2), so it can act as "none".
  function automatic int cnt_width(input int sets);
    return $clog2(sets + 1);
  endfunction

endpackage

// File: rtl/alu_seq_scoreboard.sv
// Pass/fail tally and first-failure capture for one sequencer run.
module alu_seq_scoreboard #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          check_en,
  input  logic          match,
  input  logic [CW-1:0] idx,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [CW-1:0] first_fail
);

  // Count one result per check strobe; remember the index of the earliest failure.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '1;
    end else if (check_en) begin
      if (match) begin
        pass_cnt <= pass_cnt + 1'b1;
      end else begin
        fail_cnt <= fail_cnt + 1'b1;
        if (first_fail == '1) begin
          first_fail <= idx;
        end
      end
    end
  end

endmodule

// File: rtl/alu_test_sequencer.sv
// Walks a run of test vectors through an external ALU and scores the results.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_FETCH | vec_ready high, waiting for the source to present a vector
// S_ISSUE | one-cycle alu_req with the captured operands
// S_WAIT  | waiting for alu_ack, bounded by TIMEOUT cycles
// S_CHECK | one cycle: score the result, advance idx
// S_DONE  | run complete, results held until the next start
module alu_test_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SETS    = 16,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 64,
  localparam int CW     = cnt_width(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [OPW-1:0]   vec_op,
  input  logic [WIDTH-1:0] vec_exp,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic             alu_ack,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    pass_cnt,
  output logic [CW-1:0]    fail_cnt,
  output logic [CW-1:0]    first_fail,
  output logic             timeout_flag
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_range
    $error("alu_test_sequencer: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end else if (WIDTH > WIDTH_WARN) begin : g_width_large
    $warning("alu_test_sequencer: WIDTH=%0d above %0d", WIDTH, WIDTH_WARN);
  end

  if (SETS < SETS_MIN || SETS > SETS_MAX) begin : g_sets_range
    $error("alu_test_sequencer: SETS=%0d outside %0d..%0d", SETS, SETS_MIN, SETS_MAX);
  end else if (SETS > SETS_WARN) begin : g_sets_large
    $warning("alu_test_sequencer: SETS=%0d above %0d", SETS, SETS_WARN);
  end

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("alu_test_sequencer: TIMEOUT=%0d must be at least 1", TIMEOUT);
  end

  seq_state_t       state;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] res_q;
  logic             timed_out;
  logic [TW-1:0]    wait_cnt;
  logic [CW-1:0]    idx;

  logic check_en;
  logic match;
  logic run_clear;

  // alu_a/b/op double as the captured vector, so they stay put until the next fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      vec_ready    <= 1'b0;
      alu_req      <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      exp_q        <= '0;
      res_q        <= '0;
      timed_out    <= 1'b0;
      timeout_flag <= 1'b0;
      wait_cnt     <= '0;
      idx          <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_FETCH;
            busy         <= 1'b1;
            done         <= 1'b0;
            vec_ready    <= 1'b1;
            timeout_flag <= 1'b0;
            idx          <= '0;
          end
        end
        S_FETCH: begin
          if (vec_valid && vec_ready) begin
            alu_a     <= vec_a;
            alu_b     <= vec_b;
            alu_op    <= vec_op;
            exp_q     <= vec_exp;
            vec_ready <= 1'b0;
            alu_req   <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_req   <= 1'b0;
          wait_cnt  <= '0;
          timed_out <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // An ack on the final wait cycle still counts as a response.
          if (alu_ack) begin
            res_q <= alu_res;
            state <= S_CHECK;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timed_out    <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          idx <= idx + 1'b1;
          if (idx == CW'(SETS - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_FETCH;
            vec_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A timed-out vector fails regardless of whatever stale value sits in res_q.
  always_comb begin
    check_en  = (state == S_CHECK);
    match     = !timed_out && (res_q == exp_q);
    run_clear = start && ((state == S_IDLE) || (state == S_DONE));
  end

  alu_seq_scoreboard #(
    .CW(CW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clear     (run_clear),
    .check_en  (check_en),
    .match     (match),
    .idx       (idx),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .first_fail(first_fail)
  );

endmodule

// File: tb/tb_alu_test_sequencer.sv
// Directed bench: table of 4-vector runs plus reset, stall and start-while-busy sequences.
module tb_alu_test_sequencer;

  localparam int WIDTH   = 8;
  localparam int SETS    = 4;
  localparam int OPW     = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = 3;
  localparam int NCASE   = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_a, vec_b, vec_exp;
  logic [OPW-1:0]   vec_op;
  logic             alu_req;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_ack;
  logic [WIDTH-1:0] alu_res;
  logic             busy, done;
  logic [CW-1:0]    pass_cnt, fail_cnt, first_fail;
  logic             timeout_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Per-vector stimulus plus expected run outcome. dly = cycles from req to ack, 0 = never.
  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][7:0] ex;
    logic [3:0][7:0] res;
    logic [3:0][3:0] op;
    logic [3:0][3:0] dly;
    logic [2:0]      x_pass;
    logic [2:0]      x_fail;
    logic [2:0]      x_ff;
    logic            x_to;
    logic [7:0]      x_cyc;
  } run_t;

  run_t cases [NCASE];

  alu_test_sequencer #(
    .WIDTH  (WIDTH),
    .SETS   (SETS),
    .OPW    (OPW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_a       (vec_a),
    .vec_b       (vec_b),
    .vec_op      (vec_op),
    .vec_exp     (vec_exp),
    .alu_req     (alu_req),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_ack     (alu_ack),
    .alu_res     (alu_res),
    .busy        (busy),
    .done        (done),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .first_fail  (first_fail),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {busy, done, vec_ready, alu_req, timeout_flag}, 0);
    chk({tag, "_bus"}, {alu_a, alu_b, alu_op}, 0);
    chk({tag, "_cnt"}, {pass_cnt, fail_cnt}, 0);
    chk({tag, "_ff"}, first_fail, 3'h7);
  endtask

  function automatic run_t base_run();
    run_t r;
    r = '0;
    r.a[0] = 8'h12; r.b[0] = 8'h34; r.op[0] = 4'd0; r.ex[0] = 8'h46;
    r.a[1] = 8'hF0; r.b[1] = 8'h0F; r.op[1] = 4'd1; r.ex[1] = 8'hFF;
    r.a[2] = 8'h09; r.b[2] = 8'h04; r.op[2] = 4'd2; r.ex[2] = 8'h05;
    r.a[3] = 8'hAA; r.b[3] = 8'h55; r.op[3] = 4'd3; r.ex[3] = 8'h00;
    for (int v = 0; v < 4; v++) begin
      r.res[v] = r.ex[v];
      r.dly[v] = 4'd1;
    end
    r.x_pass = 3'd4; r.x_fail = 3'd0; r.x_ff = 3'h7; r.x_to = 1'b0; r.x_cyc = 8'd16;
    return r;
  endfunction

  // Runs one sequencer pass, acting as vector source and ALU.
  // stall_len: cycles vec_valid is held low in the FETCH of vector 1.
  // busy_start_at: cycle to pulse start mid-run (-1 none); rst_at: cycle to assert rst (-1 none).
  task automatic run(input string tag, input run_t r, input int stall_len,
                     input int busy_start_at, input int rst_at, output bit aborted);
    int cyc, src, iss, cur, pend, reqs, stall_rem;
    bit accept, stall_bad;
    cyc = 0; src = 0; iss = 0; cur = 0; pend = 0; reqs = 0;
    stall_rem = stall_len; stall_bad = 1'b0; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (cyc < 200) begin
      @(negedge clk);
      start = (cyc == busy_start_at);
      if (cyc == 0) begin
        chk({tag, "_start_clear"},
            {busy, done, pass_cnt, fail_cnt, first_fail, timeout_flag},
            {1'b1, 1'b0, 3'd0, 3'd0, 3'h7, 1'b0});
      end
      if (done) break;
      if (cyc == rst_at) begin
        chk({tag, "_pre_rst_ff"}, first_fail, r.x_ff);
        rst = 1'b1; alu_ack = 1'b0; vec_valid = 1'b0; start = 1'b0;
        @(posedge clk);
        aborted = 1'b1;
        break;
      end
      alu_ack = 1'b0;
      if (pend > 0) begin
        chk({tag, "_op_hold"}, {alu_a, alu_b, alu_op}, {r.a[cur], r.b[cur], r.op[cur]});
        pend--;
        if (pend == 0) begin
          alu_ack = 1'b1;
          alu_res = r.res[cur];
        end
      end
      if (alu_req) begin
        cur = iss;
        iss++;
        reqs++;
        chk({tag, "_issue"}, {alu_a, alu_b, alu_op}, {r.a[cur], r.b[cur], r.op[cur]});
        pend = int'(r.dly[cur]);
      end
      if (stall_rem > 0 && vec_ready && src == 1) begin
        stall_rem--;
        vec_valid = 1'b0;
        if (alu_req || (pass_cnt + fail_cnt) != 1) stall_bad = 1'b1;
      end else if (src < 4) begin
        vec_valid = 1'b1;
        vec_a = r.a[src]; vec_b = r.b[src]; vec_op = r.op[src]; vec_exp = r.ex[src];
      end else begin
        vec_valid = 1'b0;
      end
      accept = vec_valid && vec_ready;
      @(posedge clk);
      if (accept) src++;
      cyc++;
    end
    if (!aborted) begin
      chk({tag, "_done"}, {done, busy}, 2'b10);
      chk({tag, "_pass"}, pass_cnt, r.x_pass);
      chk({tag, "_fail"}, fail_cnt, r.x_fail);
      chk({tag, "_first_fail"}, first_fail, r.x_ff);
      chk({tag, "_timeout"}, timeout_flag, r.x_to);
      chk({tag, "_cycles"}, cyc, int'(r.x_cyc) + stall_len);
      chk({tag, "_reqs"}, reqs, 4);
      if (stall_len > 0) chk({tag, "_stall_quiet"}, stall_bad, 0);
    end
    vec_valid = 1'b0;
    alu_ack = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    bit ab;
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; alu_ack = 1'b0;
    vec_a = '0; vec_b = '0; vec_op = '0; vec_exp = '0; alu_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Ack while idle is ignored.
    alu_ack = 1'b1; alu_res = 8'h5A;
    repeat (2) @(negedge clk);
    alu_ack = 1'b0;
    chk("idle_ack_ignored", {busy, done, vec_ready, alu_req, pass_cnt, fail_cnt}, 0);

    cases[0] = base_run();
    cases[1] = base_run(); cases[1].res[2] = 8'h06;
    cases[1].x_pass = 3; cases[1].x_fail = 1; cases[1].x_ff = 2;
    cases[2] = base_run(); cases[2].dly[1] = 4'd0;
    cases[2].x_pass = 3; cases[2].x_fail = 1; cases[2].x_ff = 1; cases[2].x_to = 1; cases[2].x_cyc = 23;
    cases[3] = base_run(); cases[3].res[0] = 8'h47; cases[3].res[3] = 8'h01;
    cases[3].x_pass = 2; cases[3].x_fail = 2; cases[3].x_ff = 0;
    cases[4] = base_run(); cases[4].dly[0] = 4'd0; cases[4].res[1] = 8'hFE; cases[4].res[2] = 8'h00;
    cases[4].x_pass = 1; cases[4].x_fail = 3; cases[4].x_ff = 0; cases[4].x_to = 1; cases[4].x_cyc = 23;
    cases[5] = base_run(); cases[5].dly[0] = 4'd8; cases[5].x_cyc = 23;
    cases[6] = base_run(); cases[6].dly[2] = 4'd9;
    cases[6].x_pass = 3; cases[6].x_fail = 1; cases[6].x_ff = 2; cases[6].x_to = 1; cases[6].x_cyc = 23;
    cases[7] = base_run();
    cases[7].dly[0] = 4'd2; cases[7].dly[1] = 4'd1; cases[7].dly[2] = 4'd3; cases[7].dly[3] = 4'd2;
    cases[7].x_cyc = 20;

    for (int i = 0; i < NCASE; i++) begin
      run($sformatf("c%0d", i), cases[i], 0, -1, -1, ab);
      // Results hold in DONE, even with a stray ack.
      alu_ack = 1'b1; alu_res = 8'h00;
      repeat (3) @(negedge clk);
      alu_ack = 1'b0;
      chk($sformatf("c%0d_hold", i), {done, busy, pass_cnt, fail_cnt, first_fail},
          {1'b1, 1'b0, cases[i].x_pass, cases[i].x_fail, cases[i].x_ff});
    end

    run("stall", cases[0], 10, -1, -1, ab);
    run("busy_start", cases[0], 0, 5, -1, ab);

    // Reset during WAIT of vector 1, with vector 0 already failed.
    run("rst_mid", cases[3], 0, -1, 6, ab);
    chk("rst_mid_aborted", ab, 1);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    alu_ack = 1'b1; alu_res = 8'h46;
    repeat (2) @(negedge clk);
    alu_ack = 1'b0;
    chk("late_ack_ignored", {busy, done, vec_ready, alu_req, pass_cnt, fail_cnt}, 0);
    run("after_rst", cases[0], 0, -1, -1, ab);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
